// File: rtl/mef_principal.sv
// Main control FSM of the vending machine: product selection, quarter accumulation,
// exact-change dispense or refund, with timed message/refund holds and an inactivity cancel.
module mef_principal #(
  parameter int TEMPO_MSG     = 100000000,
  parameter int TEMPO_INATIVO = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] codigo,
  input  logic       confirmar,
  input  logic       cancelar,
  input  logic       moeda25,
  input  logic       moeda50,
  input  logic       moeda100,
  output logic [1:0] estado,
  output logic [3:0] produto,
  output logic [3:0] valorMoedas,
  output logic       devolver,
  output logic       liberar,
  output logic [3:0] troco,
  output logic       aceitarMoeda
);

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    PRODUTO    = 2'b01,
    COMPARADOR = 2'b10,
    ENTREGA    = 2'b11
  } estado_t;

  localparam logic [3:0]  INVALIDO    = 4'hF;
  localparam logic [31:0] MSG_FIM     = 32'(TEMPO_MSG - 1);
  localparam logic [31:0] INATIVO_FIM = 32'(TEMPO_INATIVO - 1);

  // Price in quarters; 0 marks a code that is not on sale.
  function automatic logic [3:0] preco(input logic [3:0] c);
    case (c)
      4'b0000: preco = 4'd6;
      4'b0100: preco = 4'd7;
      4'b0101: preco = 4'd4;
      4'b1000: preco = 4'd4;
      4'b1001: preco = 4'd6;
      4'b1010: preco = 4'd7;
      4'b1011: preco = 4'd2;
      4'b1100: preco = 4'd8;
      4'b1101: preco = 4'd8;
      default: preco = 4'd0;
    endcase
  endfunction

  estado_t     st;
  logic [31:0] msg_cnt;
  logic [31:0] ina_cnt;

  logic [2:0] moedas;
  logic       tem_moeda;
  logic [3:0] soma;
  logic [3:0] preco_atual;
  logic       codigo_valido;
  logic       msg_fim;
  logic       ina_fim;

  // Coin weights 1/2/4 line up with bit positions, so the per-cycle sum is a concatenation.
  assign moedas        = {moeda100, moeda50, moeda25};
  assign tem_moeda     = |moedas;
  assign soma          = valorMoedas + {1'b0, moedas};
  assign preco_atual   = preco(produto);
  assign codigo_valido = (preco(codigo) != 4'd0);
  assign msg_fim       = (msg_cnt == MSG_FIM);
  assign ina_fim       = (ina_cnt == INATIVO_FIM);
  assign estado        = st;

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; blocking assignments would leak new values into later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ESPERA;
      produto      <= 4'd0;
      valorMoedas  <= 4'd0;
      troco        <= 4'd0;
      devolver     <= 1'b0;
      liberar      <= 1'b0;
      aceitarMoeda <= 1'b0;
      msg_cnt      <= '0;
      ina_cnt      <= '0;
    end else begin
      liberar <= 1'b0;
      unique case (st)
        ESPERA: begin
          if (confirmar) begin
            st           <= PRODUTO;
            produto      <= codigo_valido ? codigo : INVALIDO;
            aceitarMoeda <= codigo_valido;
            msg_cnt      <= '0;
            ina_cnt      <= '0;
          end
        end

        PRODUTO: begin
          if (produto == INVALIDO) begin
            if (msg_fim) st <= ESPERA;
            else         msg_cnt <= msg_cnt + 32'd1;
          end else if (tem_moeda) begin
            // The first coin is judged immediately, exactly like a coin in COMPARADOR.
            valorMoedas <= soma;
            ina_cnt     <= '0;
            msg_cnt     <= '0;
            if (cancelar || soma > preco_atual) begin
              st           <= COMPARADOR;
              devolver     <= 1'b1;
              troco        <= soma;
              aceitarMoeda <= 1'b0;
            end else if (soma == preco_atual) begin
              st           <= ENTREGA;
              liberar      <= 1'b1;
              aceitarMoeda <= 1'b0;
            end else begin
              st <= COMPARADOR;
            end
          end else if (cancelar || ina_fim) begin
            st           <= ESPERA;
            aceitarMoeda <= 1'b0;
          end else if (confirmar) begin
            produto      <= codigo_valido ? codigo : INVALIDO;
            aceitarMoeda <= codigo_valido;
            msg_cnt      <= '0;
            ina_cnt      <= '0;
          end else begin
            ina_cnt <= ina_cnt + 32'd1;
          end
        end

        COMPARADOR: begin
          if (devolver) begin
            if (msg_fim) begin
              st          <= ESPERA;
              valorMoedas <= 4'd0;
              troco       <= 4'd0;
              devolver    <= 1'b0;
            end else begin
              msg_cnt <= msg_cnt + 32'd1;
            end
          end else if (tem_moeda) begin
            valorMoedas <= soma;
            ina_cnt     <= '0;
            msg_cnt     <= '0;
            if (cancelar || soma > preco_atual) begin
              devolver     <= 1'b1;
              troco        <= soma;
              aceitarMoeda <= 1'b0;
            end else if (soma == preco_atual) begin
              st           <= ENTREGA;
              liberar      <= 1'b1;
              aceitarMoeda <= 1'b0;
            end
          end else if (cancelar || ina_fim) begin
            devolver     <= 1'b1;
            troco        <= valorMoedas;
            aceitarMoeda <= 1'b0;
            msg_cnt      <= '0;
          end else begin
            ina_cnt <= ina_cnt + 32'd1;
          end
        end

        ENTREGA: begin
          if (msg_fim) begin
            st          <= ESPERA;
            valorMoedas <= 4'd0;
          end else begin
            msg_cnt <= msg_cnt + 32'd1;
          end
        end

        default: st <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_mef_principal.sv
// Bench for mef_principal: a transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mef_principal;

  localparam int TM = 8;
  localparam int TI = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] codigo;
  logic       confirmar, cancelar, moeda25, moeda50, moeda100;
  logic [1:0] estado;
  logic [3:0] produto, valorMoedas, troco;
  logic       devolver, liberar, aceitarMoeda;

  int n_checks = 0;
  int n_fail   = 0;

  mef_principal #(.TEMPO_MSG(TM), .TEMPO_INATIVO(TI)) dut (
    .clk(clk), .rst_n(rst_n), .codigo(codigo), .confirmar(confirmar),
    .cancelar(cancelar), .moeda25(moeda25), .moeda50(moeda50), .moeda100(moeda100),
    .estado(estado), .produto(produto), .valorMoedas(valorMoedas),
    .devolver(devolver), .liberar(liberar), .troco(troco), .aceitarMoeda(aceitarMoeda)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int price_tab[16] = '{6, 0, 0, 0, 7, 4, 0, 0, 4, 6, 7, 2, 8, 8, 0, 0};

  typedef struct packed {
    int est;    // 0 standby, 1 product, 2 paying / refunding, 3 delivering
    int prod;
    int val;
    int troco;
    int hold;   // cycles left in a timed hold
    int idle;   // consecutive cycles without activity
    bit dev;
    bit lib;
  } model_t;

  model_t m;

  function automatic model_t select(model_t s, int code);
    model_t n = s;
    n.est  = 1;
    n.prod = (price_tab[code] > 0) ? code : 15;
    n.idle = 0;
    n.hold = TM;
    return n;
  endfunction

  function automatic model_t pay(model_t s, int coin, bit canc);
    model_t n = s;
    int total = s.val + coin;
    int price = price_tab[s.prod];
    n.val  = total;
    n.idle = 0;
    n.hold = TM;
    n.est  = 2;
    if (canc || total > price) begin
      n.dev   = 1;
      n.troco = total;
    end else if (total == price) begin
      n.est = 3;
      n.lib = 1;
    end
    return n;
  endfunction

  function automatic model_t step(model_t s, int code, bit conf, bit canc, int coin);
    model_t n = s;
    n.lib = 0;
    case (s.est)
      0: if (conf) n = select(n, code);
      1: begin
        if (s.prod == 15) begin
          n.hold = s.hold - 1;
          if (n.hold == 0) n.est = 0;
        end else if (coin > 0) n = pay(n, coin, canc);
        else if (canc) n.est = 0;
        else if (conf) n = select(n, code);
        else begin
          n.idle = s.idle + 1;
          if (n.idle == TI) n.est = 0;
        end
      end
      2: begin
        if (s.dev) begin
          n.hold = s.hold - 1;
          if (n.hold == 0) begin
            n.est = 0; n.val = 0; n.troco = 0; n.dev = 0;
          end
        end else if (coin > 0) n = pay(n, coin, canc);
        else begin
          n.idle = s.idle + 1;
          if (canc || n.idle == TI) begin
            n.dev = 1; n.troco = s.val; n.hold = TM;
          end
        end
      end
      default: begin
        n.hold = s.hold - 1;
        if (n.hold == 0) begin
          n.est = 0; n.val = 0;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, int'(codigo), confirmar, cancelar,
                   int'(moeda25) + 2 * int'(moeda50) + 4 * int'(moeda100));
  end

  always @(negedge clk) begin
    check("m_estado", int'(estado), m.est);
    check("m_produto", int'(produto), m.prod);
    check("m_valor", int'(valorMoedas), m.val);
    check("m_troco", int'(troco), m.troco);
    check("m_devolver", int'(devolver), int'(m.dev));
    check("m_liberar", int'(liberar), int'(m.lib));
    check("m_aceitar", int'(aceitarMoeda),
          int'((m.est == 1 && m.prod != 15) || (m.est == 2 && !m.dev)));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Holds the given inputs across exactly one rising edge, then clears them.
  task automatic drive(input logic [3:0] c, input logic cf, input logic cn,
                       input logic a, input logic b, input logic d);
    codigo = c; confirmar = cf; cancelar = cn;
    moeda25 = a; moeda50 = b; moeda100 = d;
    @(negedge clk);
    confirmar = 0; cancelar = 0; moeda25 = 0; moeda50 = 0; moeda100 = 0;
  endtask

  task automatic wait_espera(input string name);
    int n = 0;
    while (estado != 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check(name, int'(estado), 0);
  endtask

  initial begin
    rst_n = 0; codigo = 0; confirmar = 0; cancelar = 0;
    moeda25 = 0; moeda50 = 0; moeda100 = 0;
    tick(2);
    check("rst_estado", int'(estado), 0);
    check("rst_produto", int'(produto), 0);
    check("rst_aceitar", int'(aceitarMoeda), 0);
    rst_n = 1;

    // Standby ignores coins and cancel.
    drive(4'd0, 0, 1, 0, 0, 1);
    check("espera_ignora_estado", int'(estado), 0);
    check("espera_ignora_valor", int'(valorMoedas), 0);

    // Exact pay: 0101 costs 4.
    drive(4'b0101, 1, 0, 0, 0, 0);
    check("exato_estado_prod", int'(estado), 1);
    check("exato_produto", int'(produto), 5);
    check("exato_aceitar", int'(aceitarMoeda), 1);
    drive(4'd0, 0, 0, 0, 0, 1);
    check("exato_estado_entrega", int'(estado), 3);
    check("exato_liberar", int'(liberar), 1);
    check("exato_valor", int'(valorMoedas), 4);
    tick();
    check("exato_liberar_fim", int'(liberar), 0);
    tick(6);
    check("exato_ainda_entrega", int'(estado), 3);
    tick();
    check("exato_espera", int'(estado), 0);
    check("exato_valor_zero", int'(valorMoedas), 0);

    // Simultaneous coins: 1100 costs 8.
    drive(4'b1100, 1, 0, 0, 0, 0);
    drive(4'd0, 0, 0, 0, 1, 1);
    check("multi_valor6", int'(valorMoedas), 6);
    check("multi_estado_comp", int'(estado), 2);
    drive(4'd0, 0, 0, 0, 1, 0);
    check("multi_valor8", int'(valorMoedas), 8);
    check("multi_entrega", int'(estado), 3);
    check("multi_liberar", int'(liberar), 1);
    wait_espera("multi_volta_espera");

    // Overpay: 1011 costs 2, paid with 4.
    drive(4'b1011, 1, 0, 0, 0, 0);
    drive(4'd0, 0, 0, 0, 0, 1);
    check("sobra_estado", int'(estado), 2);
    check("sobra_devolver", int'(devolver), 1);
    check("sobra_troco", int'(troco), 4);
    check("sobra_liberar", int'(liberar), 0);
    check("sobra_aceitar", int'(aceitarMoeda), 0);
    tick(7);
    check("sobra_ainda_devolve", int'(devolver), 1);
    tick();
    check("sobra_espera", int'(estado), 0);
    check("sobra_troco_zero", int'(troco), 0);
    check("sobra_devolver_zero", int'(devolver), 0);
    check("sobra_valor_zero", int'(valorMoedas), 0);

    // Invalid code holds for TM cycles and ignores coins.
    drive(4'b0011, 1, 0, 0, 0, 0);
    check("inval_produto", int'(produto), 15);
    check("inval_estado", int'(estado), 1);
    check("inval_aceitar", int'(aceitarMoeda), 0);
    drive(4'd0, 0, 0, 0, 0, 1);
    check("inval_moeda_ignorada", int'(valorMoedas), 0);
    tick(6);
    check("inval_ultimo_ciclo", int'(estado), 1);
    tick();
    check("inval_espera", int'(estado), 0);

    // Product change before payment: 0101 then 1011 (price 2).
    drive(4'b0101, 1, 0, 0, 0, 0);
    drive(4'b1011, 1, 0, 0, 0, 0);
    check("troca_produto", int'(produto), 11);
    drive(4'd0, 0, 0, 0, 1, 0);
    check("troca_entrega", int'(estado), 3);
    wait_espera("troca_volta_espera");

    // Cancel in the same cycle as a coin: 0000 costs 6.
    drive(4'b0000, 1, 0, 0, 0, 0);
    drive(4'd0, 0, 0, 1, 0, 0);
    check("cancela_valor1", int'(valorMoedas), 1);
    drive(4'd0, 0, 1, 0, 1, 0);
    check("cancela_troco", int'(troco), 3);
    check("cancela_devolver", int'(devolver), 1);
    check("cancela_valor", int'(valorMoedas), 3);
    wait_espera("cancela_volta_espera");

    // Inactivity timeout in COMPARADOR.
    drive(4'b0000, 1, 0, 0, 0, 0);
    drive(4'd0, 0, 0, 1, 0, 0);
    tick(TI - 1);
    check("inativo_antes", int'(devolver), 0);
    tick();
    check("inativo_devolver", int'(devolver), 1);
    check("inativo_troco", int'(troco), 1);
    wait_espera("inativo_volta_espera");

    // Reset in the middle of ENTREGA.
    drive(4'b1011, 1, 0, 0, 0, 0);
    drive(4'd0, 0, 0, 0, 1, 0);
    tick(2);
    check("reset_pre_entrega", int'(estado), 3);
    #2 rst_n = 0;
    #1;
    check("reset_estado", int'(estado), 0);
    check("reset_valor", int'(valorMoedas), 0);
    check("reset_produto", int'(produto), 0);
    check("reset_liberar", int'(liberar), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("reset_sem_liberar", int'(liberar), 0);
    end
    check("reset_fica_espera", int'(estado), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
